// File: rtl/can_bit_sync_ctrl_if.sv
// Prescaler-side inputs and bit-stream-side outputs of the CAN bit-timing controller.
interface can_bit_sync_ctrl_if;
    logic       tq_tick;
    logic [3:0] tseg1;
    logic [2:0] tseg2;
    logic [1:0] sjw;
    logic       hard_sync_en;
    logic       rx;
    logic [1:0] seg;
    logic [4:0] tq_cnt;
    logic       sample_point;
    logic       rx_bit;
    logic       bit_tick;
    logic       sync_evt;

    modport master (
        output tq_tick, tseg1, tseg2, sjw, hard_sync_en, rx,
        input  seg, tq_cnt, sample_point, rx_bit, bit_tick, sync_evt
    );

    modport slave (
        input  tq_tick, tseg1, tseg2, sjw, hard_sync_en, rx,
        output seg, tq_cnt, sample_point, rx_bit, bit_tick, sync_evt
    );
endinterface

// File: rtl/can_bit_sync_ctrl.sv
// CAN bit-timing controller: sequences TQs into SYNC/TSEG1/TSEG2 with hard sync
// and SJW-limited resynchronisation, producing sample-point and bit-boundary strobes.
module can_bit_sync_ctrl #(
    parameter int unsigned RX_SYNC_STAGES = 2
) (
    input logic          clk,
    input logic          rst,
    can_bit_sync_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        SEG_SYNC  = 2'd0,
        SEG_TSEG1 = 2'd1,
        SEG_TSEG2 = 2'd2
    } seg_t;

    seg_t                      state;
    logic [4:0]                cnt;
    logic                      sp_q, bt_q, se_q, rx_bit_q;
    logic                      rx_prev, locked;
    logic [2:0]                ext, shr;
    logic [3:0]                tseg1_l;
    logic [2:0]                tseg2_l;
    logic [1:0]                sjw_l;
    logic [RX_SYNC_STAGES-1:0] sync_q;

    logic       rx_s, edge_det, hard, resync, early;
    logic [2:0] sjw_p1, ext_nxt, shr_nxt;
    logic [4:0] cnt_p1, l1, rem;
    logic [3:0] l2_cur, l2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= '1;
        else     sync_q <= {sync_q[RX_SYNC_STAGES-2:0], bus.rx};
    end

    // Segment lengths are evaluated with the ext/shr value this tick would write,
    // so a resync alters the end-of-segment test on the very tick it happens.
    always_comb begin
        rx_s     = sync_q[RX_SYNC_STAGES-1];
        edge_det = bus.tq_tick & rx_prev & ~rx_s;
        hard     = edge_det & bus.hard_sync_en;
        resync   = edge_det & ~bus.hard_sync_en & ~locked;
        sjw_p1   = {1'b0, sjw_l} + 3'd1;
        cnt_p1   = cnt + 5'd1;
        ext_nxt  = ext;
        if (resync && state == SEG_TSEG1)
            ext_nxt = (cnt_p1 < {2'b00, sjw_p1}) ? cnt_p1[2:0] : sjw_p1;
        l1       = {1'b0, tseg1_l} + 5'd1 + {2'b00, ext_nxt};
        l2_cur   = {1'b0, tseg2_l} + 4'd1 - {1'b0, shr};
        rem      = {1'b0, l2_cur} - cnt;
        early    = resync && (state == SEG_TSEG2) && (rem <= {2'b00, sjw_p1});
        shr_nxt  = shr;
        if (resync && state == SEG_TSEG2 && !early)
            shr_nxt = sjw_p1;
        l2       = {1'b0, tseg2_l} + 4'd1 - {1'b0, shr_nxt};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= SEG_SYNC;
            cnt      <= '0;
            sp_q     <= 1'b0;
            bt_q     <= 1'b0;
            se_q     <= 1'b0;
            rx_bit_q <= 1'b1;
            rx_prev  <= 1'b1;
            locked   <= 1'b0;
            ext      <= '0;
            shr      <= '0;
            tseg1_l  <= '0;
            tseg2_l  <= '0;
            sjw_l    <= '0;
        end else begin
            sp_q <= 1'b0;
            bt_q <= 1'b0;
            se_q <= 1'b0;
            if (bus.tq_tick) begin
                rx_prev <= rx_s;
                if (hard) begin
                    state   <= SEG_TSEG1;
                    cnt     <= '0;
                    ext     <= '0;
                    shr     <= '0;
                    tseg1_l <= bus.tseg1;
                    tseg2_l <= bus.tseg2;
                    sjw_l   <= bus.sjw;
                    se_q    <= 1'b1;
                    locked  <= 1'b1;
                end else begin
                    case (state)
                        SEG_SYNC: begin
                            tseg1_l <= bus.tseg1;
                            tseg2_l <= bus.tseg2;
                            sjw_l   <= bus.sjw;
                            state   <= SEG_TSEG1;
                            cnt     <= '0;
                        end
                        SEG_TSEG1: begin
                            ext <= ext_nxt;
                            if (resync) begin
                                se_q   <= 1'b1;
                                locked <= 1'b1;
                            end
                            if (cnt == l1 - 5'd1) begin
                                sp_q     <= 1'b1;
                                rx_bit_q <= rx_s;
                                state    <= SEG_TSEG2;
                                cnt      <= '0;
                                locked   <= 1'b0;
                            end else begin
                                cnt <= cnt_p1;
                            end
                        end
                        SEG_TSEG2: begin
                            if (resync) begin
                                se_q   <= 1'b1;
                                locked <= 1'b1;
                            end
                            if (early) begin
                                bt_q  <= 1'b1;
                                state <= SEG_TSEG1;
                                cnt   <= '0;
                                ext   <= '0;
                                shr   <= '0;
                            end else if (cnt == {1'b0, l2 - 4'd1}) begin
                                bt_q  <= 1'b1;
                                state <= SEG_SYNC;
                                cnt   <= '0;
                                ext   <= '0;
                                shr   <= '0;
                            end else begin
                                shr <= shr_nxt;
                                cnt <= cnt_p1;
                            end
                        end
                        default: begin
                            state <= SEG_SYNC;
                            cnt   <= '0;
                        end
                    endcase
                end
            end
        end
    end

    assign bus.seg          = state;
    assign bus.tq_cnt       = cnt;
    assign bus.sample_point = sp_q;
    assign bus.rx_bit       = rx_bit_q;
    assign bus.bit_tick     = bt_q;
    assign bus.sync_evt     = se_q;
endmodule

// File: tb/tb_can_bit_sync_ctrl.sv
// Directed bench for can_bit_sync_ctrl: free-running timing, hard sync, resync cases,
// lockout and asynchronous reset mid-bit.
module tb_can_bit_sync_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    can_bit_sync_ctrl_if bus();

    can_bit_sync_ctrl #(.RX_SYNC_STAGES(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input int s, input int c,
                            input int sp, input int bt, input int se);
        chk({tag, ".seg"}, 32'(bus.seg), s);
        chk({tag, ".cnt"}, 32'(bus.tq_cnt), c);
        chk({tag, ".sp"},  32'(bus.sample_point), sp);
        chk({tag, ".bt"},  32'(bus.bit_tick), bt);
        chk({tag, ".se"},  32'(bus.sync_evt), se);
    endtask

    // One TQ of 4 clks; returns on the negedge right after the tick edge.
    task automatic tq_step();
        repeat (3) @(negedge clk);
        bus.tq_tick = 1'b1;
        @(negedge clk);
        bus.tq_tick = 1'b0;
    endtask

    // p is the TQ index within a bit (0 = SYNC) reached after each tick.
    task automatic run_nominal(input string tag, input int l1, input int l2,
                               input int startp, input int n);
        int p;
        int es, ec;
        p = startp;
        for (int i = 0; i < n; i++) begin
            p = (p + 1) % (l1 + l2 + 1);
            tq_step();
            if (p == 0)       begin es = 0; ec = 0;          end
            else if (p <= l1) begin es = 1; ec = p - 1;      end
            else              begin es = 2; ec = p - 1 - l1; end
            chk_outs($sformatf("%s.p%0d", tag, p), es, ec,
                     (p == l1 + 1) ? 1 : 0, (p == 0) ? 1 : 0, 0);
        end
    endtask

    initial begin
        bus.tq_tick      = 1'b0;
        bus.tseg1        = 4'd5;
        bus.tseg2        = 3'd2;
        bus.sjw          = 2'd0;
        bus.hard_sync_en = 1'b0;
        bus.rx           = 1'b1;

        repeat (3) @(negedge clk);
        chk_outs("rst", 0, 0, 0, 0, 0);
        chk("rst.rx_bit", 32'(bus.rx_bit), 1);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk_outs("rst_hold", 0, 0, 0, 0, 0);

        // free-running: 10 TQ bits, sample at the 7th TQ
        run_nominal("free", 6, 3, 0, 20);
        chk("free.rx_bit", 32'(bus.rx_bit), 1);

        // hard sync seen at TSEG2 cnt 1
        bus.hard_sync_en = 1'b1;
        run_nominal("hs_pre", 6, 3, 0, 8);
        bus.rx = 1'b0;
        tq_step();
        chk_outs("hs_edge", 1, 0, 0, 0, 1);
        bus.hard_sync_en = 1'b0;
        run_nominal("hs_post", 6, 3, 1, 6);
        chk("hs.rx_bit", 32'(bus.rx_bit), 0);
        run_nominal("hs_tail", 6, 3, 7, 3);
        bus.rx = 1'b1;

        // late edge at TSEG1 cnt 2 with SJW 2 -> ext 2, 12 TQ bit
        bus.sjw = 2'd1;
        run_nominal("late_pre", 6, 3, 0, 3);
        bus.rx = 1'b0;
        tq_step();
        chk_outs("late_edge", 1, 3, 0, 0, 1);
        run_nominal("late_post", 8, 3, 4, 8);
        bus.rx = 1'b1;
        run_nominal("late_next", 6, 3, 0, 10);

        // early edge within SJW: TSEG2 cnt 2 of 4
        bus.tseg2 = 3'd3;
        run_nominal("ein_pre", 6, 4, 0, 9);
        bus.rx = 1'b0;
        tq_step();
        chk_outs("ein_edge", 1, 0, 0, 1, 1);
        bus.rx = 1'b1;
        run_nominal("ein_post", 6, 4, 1, 10);

        // early edge beyond SJW: shr 1, TSEG2 7 TQ, bit 14 TQ
        bus.tseg2 = 3'd7;
        bus.sjw   = 2'd0;
        run_nominal("eout_pre", 6, 8, 0, 8);
        bus.rx = 1'b0;
        tq_step();
        chk_outs("eout_edge", 2, 2, 0, 0, 1);
        run_nominal("eout_post", 6, 7, 9, 5);
        bus.rx = 1'b1;
        run_nominal("eout_next", 6, 8, 0, 15);

        // lockout: second edge before sample point is ignored (SJW 4 would otherwise extend)
        bus.tseg2 = 3'd2;
        bus.sjw   = 2'd3;
        run_nominal("lk_pre", 6, 3, 0, 1);
        bus.rx = 1'b0;
        tq_step();
        chk_outs("lk_edge1", 1, 1, 0, 0, 1);
        bus.rx = 1'b1;
        tq_step();
        chk_outs("lk_gap", 1, 2, 0, 0, 0);
        bus.rx = 1'b0;
        tq_step();
        chk_outs("lk_edge2", 1, 3, 0, 0, 0);
        run_nominal("lk_post", 7, 3, 4, 7);
        chk("lk.rx_bit", 32'(bus.rx_bit), 0);
        bus.rx = 1'b1;

        // asynchronous reset mid-TSEG1
        run_nominal("mr_pre", 6, 3, 0, 3);
        chk("mr_pre.rx_bit", 32'(bus.rx_bit), 0);
        #2 rst = 1'b1;
        #1;
        chk_outs("mr_rst", 0, 0, 0, 0, 0);
        chk("mr_rst.rx_bit", 32'(bus.rx_bit), 1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        run_nominal("mr_post", 6, 3, 0, 10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
